// File: rtl/cfg_frame_serializer.sv
// cfg_frame_serializer: serialises a dynamic/static config word onto the latch chain with SCLK, then pulses load strobes and DONE.
// Optional macro FRAME_PARITY_EN appends an even-parity bit after DYN_DATA[0].
module cfg_frame_serializer #(
    parameter int DYN_W   = 16,
    parameter int STAT_W  = 88,
    parameter int CLK_DIV = 2,
    parameter int LATCH_W = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              DYN_ONLY,
    input  logic [DYN_W-1:0]  DYN_DATA,
    input  logic [STAT_W-1:0] STAT_DATA,
    output logic              BUSY,
    output logic              SDATA,
    output logic              SCLK,
    output logic              LOAD_DYN,
    output logic              LOAD_STAT,
    output logic              DONE
);
    logic par_full, par_dyn;
`ifdef FRAME_PARITY_EN
    localparam int PAR = 1;
    assign par_full = ^{STAT_DATA, DYN_DATA};
    assign par_dyn  = ^DYN_DATA;
`else
    localparam int PAR = 0;
    assign par_full = 1'b0;
    assign par_dyn  = 1'b0;
`endif
    localparam int SW = DYN_W + STAT_W + 1;
    localparam int CW = $clog2(DYN_W + STAT_W + 2);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int LW = LATCH_W > 1 ? $clog2(LATCH_W) : 1;
    localparam logic [CW-1:0] N_FULL  = CW'(DYN_W + STAT_W + PAR);
    localparam logic [CW-1:0] N_DYN   = CW'(DYN_W + PAR);
    localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
    localparam logic [LW-1:0] LAT_END = LW'(LATCH_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, FIN} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   div_q, div_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic            hi_q, hi_d;
    logic            dyn_only_q, dyn_only_d;
    logic            accept;

    assign accept    = START && (state_q == IDLE || state_q == FIN);
    assign BUSY      = state_q != IDLE;
    assign SCLK      = state_q == SHIFT && hi_q;
    assign SDATA     = state_q == SHIFT && sreg_q[SW-1];
    assign LOAD_DYN  = state_q == LATCH;
    assign LOAD_STAT = LOAD_DYN && !dyn_only_q;
    assign DONE      = state_q == FIN;

    // Next state: SCLK phase divider, bit shifting, strobe timing and frame capture (FIN may accept the next frame directly).
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        lat_d      = lat_q;
        hi_d       = hi_q;
        dyn_only_d = dyn_only_q;
        case (state_q)
            SHIFT: begin
                if (div_q == DIV_END) begin
                    div_d = '0;
                    hi_d  = !hi_q;
                    if (hi_q) begin
                        sreg_d = {sreg_q[SW-2:0], 1'b0};
                        cnt_d  = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_d = LATCH;
                            lat_d   = '0;
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            LATCH:   if (lat_q == LAT_END) state_d = FIN; else lat_d = lat_q + LW'(1);
            FIN:     state_d = IDLE;
            default: ;
        endcase
        if (accept) begin
            state_d    = SHIFT;
            sreg_d     = DYN_ONLY ? {DYN_DATA, par_dyn, {STAT_W{1'b0}}} : {STAT_DATA, DYN_DATA, par_full};
            cnt_d      = DYN_ONLY ? N_DYN : N_FULL;
            div_d      = '0;
            hi_d       = 1'b0;
            lat_d      = '0;
            dyn_only_d = DYN_ONLY;
        end
    end

    // State registers; reset aborts any frame at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            cnt_q      <= '0;
            div_q      <= '0;
            lat_q      <= '0;
            hi_q       <= 1'b0;
            dyn_only_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            lat_q      <= lat_d;
            hi_q       <= hi_d;
            dyn_only_q <= dyn_only_d;
        end
    end
endmodule
